// File: rtl/msrv32_machine_control.sv
// msrv32_machine_control: machine-mode trap sequencer driving PC source, flush and CSR strobes.
// Rev 1.0
`default_nettype none

module msrv32_machine_control (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       e_irq_in,
  input  logic       s_irq_in,
  input  logic       t_irq_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       msie_in,
  input  logic       mtie_in,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic [3:0] cause_out,
  output logic       i_or_e_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       misaligned_exception_out
);

  localparam logic [1:0] RESET       = 2'b00;
  localparam logic [1:0] OPERATING   = 2'b01;
  localparam logic [1:0] TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] TRAP_RETURN = 2'b11;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       is_system;
  logic       is_ecall;
  logic       is_ebreak;
  logic       is_mret;
  logic       exception;
  logic       irq_ext;
  logic       irq_sw;
  logic       irq_timer;
  logic       interrupt;
  logic       trap;
  logic [3:0] exc_cause;
  logic [3:0] int_cause;
  logic [3:0] cause_reg;
  logic       i_or_e_reg;

  assign is_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                     (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign is_ecall  = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00000);
  assign is_ebreak = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00001);
  assign is_mret   = is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

  assign exception = misaligned_instr_in | illegal_instr_in | is_ecall | is_ebreak |
                     misaligned_load_in | misaligned_store_in;

  assign irq_ext   = meie_in & e_irq_in;
  assign irq_sw    = msie_in & s_irq_in;
  assign irq_timer = mtie_in & t_irq_in;
  assign interrupt = mie_in & (irq_ext | irq_sw | irq_timer);
  assign trap      = exception | interrupt;

  // Cause chains follow the architectural priority order, not numeric code order.
  always_comb begin
    exc_cause = 4'd6;
    if (misaligned_instr_in)     exc_cause = 4'd0;
    else if (illegal_instr_in)   exc_cause = 4'd2;
    else if (is_ecall)           exc_cause = 4'd11;
    else if (is_ebreak)          exc_cause = 4'd3;
    else if (misaligned_load_in) exc_cause = 4'd4;
  end

  always_comb begin
    int_cause = 4'd7;
    if (irq_ext)     int_cause = 4'd11;
    else if (irq_sw) int_cause = 4'd3;
  end

  always_comb begin
    next_state = state;
    case (state)
      RESET:       next_state = OPERATING;
      OPERATING: begin
        if (trap)         next_state = TRAP_TAKEN;
        else if (is_mret) next_state = TRAP_RETURN;
        else              next_state = OPERATING;
      end
      TRAP_TAKEN:  next_state = OPERATING;
      TRAP_RETURN: next_state = OPERATING;
      default:     next_state = RESET;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= RESET;
      cause_reg  <= 4'd0;
      i_or_e_reg <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == OPERATING) && trap) begin
        cause_reg  <= exception ? exc_cause : int_cause;
        i_or_e_reg <= ~exception;
      end
    end
  end

  always_comb begin
    pc_src_out      = PC_BOOT;
    flush_out       = 1'b1;
    trap_taken_out  = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (state)
      OPERATING: begin
        pc_src_out      = PC_NEXT;
        flush_out       = 1'b0;
        instret_inc_out = 1'b1;
      end
      TRAP_TAKEN: begin
        pc_src_out     = PC_TRAP;
        trap_taken_out = 1'b1;
        set_epc_out    = 1'b1;
        set_cause_out  = 1'b1;
        mie_clear_out  = 1'b1;
      end
      TRAP_RETURN: begin
        pc_src_out  = PC_EPC;
        mie_set_out = 1'b1;
      end
      default: begin
        pc_src_out = PC_BOOT;
      end
    endcase
  end

  assign cause_out  = cause_reg;
  assign i_or_e_out = i_or_e_reg;
  assign misaligned_exception_out = (state == OPERATING) &
                                    (misaligned_instr_in | misaligned_load_in | misaligned_store_in);

endmodule

`default_nettype wire

// File: tb/tb_msrv32_machine_control.sv
// Testbench for msrv32_machine_control: directed vector table, corner sequences, randomized model check.
`default_nettype none

module tb_msrv32_machine_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       ill, mi, ml, ms;
  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rd;
  logic       e_irq, s_irq, t_irq, mie, meie, msie, mtie;
  logic [1:0] pc_src;
  logic       flush, trap_taken, set_epc, set_cause, i_or_e, mie_clear, mie_set, instret_inc, mis_exc;
  logic [3:0] cause;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  msrv32_machine_control dut (
    .clk_in(clk), .rst_in(rst),
    .illegal_instr_in(ill), .misaligned_instr_in(mi),
    .misaligned_load_in(ml), .misaligned_store_in(ms),
    .opcode_6_to_2_in(op), .funct3_in(f3), .funct7_in(f7),
    .rs1_addr_in(rs1), .rs2_addr_in(rs2), .rd_addr_in(rd),
    .e_irq_in(e_irq), .s_irq_in(s_irq), .t_irq_in(t_irq),
    .mie_in(mie), .meie_in(meie), .msie_in(msie), .mtie_in(mtie),
    .pc_src_out(pc_src), .flush_out(flush), .trap_taken_out(trap_taken),
    .set_epc_out(set_epc), .set_cause_out(set_cause), .cause_out(cause),
    .i_or_e_out(i_or_e), .mie_clear_out(mie_clear), .mie_set_out(mie_set),
    .instret_inc_out(instret_inc), .misaligned_exception_out(mis_exc)
  );

  // Instruction kinds used by the stimulus
  localparam int K_NONE = 0, K_ECALL = 1, K_EBREAK = 2, K_MRET = 3, K_MRET_RD = 4, K_RAND = 5;

  typedef struct {
    logic        ill, mi, ml, ms;
    int          kind;
    logic [2:0]  irq;     // {e, s, t}
    logic [3:0]  en;      // {mie, meie, msie, mtie}
    logic [1:0]  exp_pc;
    logic [3:0]  exp_cause;
    logic        exp_ioe;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_instr(input int kind);
    op = 5'd0; f3 = 3'd0; f7 = 7'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    case (kind)
      K_ECALL:   op = 5'b11100;
      K_EBREAK:  begin op = 5'b11100; rs2 = 5'd1; end
      K_MRET:    begin op = 5'b11100; f7 = 7'b0011000; rs2 = 5'b00010; end
      K_MRET_RD: begin op = 5'b11100; f7 = 7'b0011000; rs2 = 5'b00010; rd = 5'd1; end
      K_RAND: begin
        op = 5'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      end
      default: ;
    endcase
  endtask

  task automatic clear_inputs();
    ill = 0; mi = 0; ml = 0; ms = 0;
    e_irq = 0; s_irq = 0; t_irq = 0; mie = 0; meie = 0; msie = 0; mtie = 0;
    set_instr(K_NONE);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Moore output table, keyed by pc_src of the expected state
  task automatic check_outputs(input string tag, input logic [1:0] exp_pc);
    check({tag, "_pc"},      pc_src,      exp_pc);
    check({tag, "_flush"},   flush,       exp_pc != 2'b11);
    check({tag, "_trap"},    trap_taken,  exp_pc == 2'b10);
    check({tag, "_epc"},     set_epc,     exp_pc == 2'b10);
    check({tag, "_scause"},  set_cause,   exp_pc == 2'b10);
    check({tag, "_mieclr"},  mie_clear,   exp_pc == 2'b10);
    check({tag, "_mieset"},  mie_set,     exp_pc == 2'b01);
    check({tag, "_instret"}, instret_inc, exp_pc == 2'b11);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (3) tick();
    rst = 0;
  endtask

  // ---------------- reference model for randomized phase ----------------
  typedef enum int {M_RESET, M_RUN, M_TRAP, M_RET} mode_t;
  mode_t      m_mode;
  logic [3:0] m_cause;
  logic       m_ioe;

  function automatic logic [1:0] mode_pc(input mode_t m);
    case (m)
      M_RUN:   return 2'b11;
      M_TRAP:  return 2'b10;
      M_RET:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step();
    logic       sys, ec, eb, mr;
    logic       exc_f[6];
    int         exc_c[6];
    logic       irq_f[3];
    int         irq_c[3];
    int         found_e, found_i;
    sys = (op == 5'b11100) && (f3 == 0) && (rs1 == 0) && (rd == 0);
    ec  = sys && f7 == 0 && rs2 == 0;
    eb  = sys && f7 == 0 && rs2 == 1;
    mr  = sys && f7 == 7'h18 && rs2 == 2;
    exc_f = '{mi, ill, ec, eb, ml, ms};
    exc_c = '{0, 2, 11, 3, 4, 6};
    irq_f = '{mie & meie & e_irq, mie & msie & s_irq, mie & mtie & t_irq};
    irq_c = '{11, 3, 7};
    found_e = -1; found_i = -1;
    for (int i = 5; i >= 0; i--) if (exc_f[i]) found_e = i;
    for (int i = 2; i >= 0; i--) if (irq_f[i]) found_i = i;
    if (rst) begin
      m_mode = M_RESET; m_cause = 0; m_ioe = 0;
    end else if (m_mode == M_RUN) begin
      if (found_e >= 0) begin
        m_mode = M_TRAP; m_cause = 4'(exc_c[found_e]); m_ioe = 0;
      end else if (found_i >= 0) begin
        m_mode = M_TRAP; m_cause = 4'(irq_c[found_i]); m_ioe = 1;
      end else if (mr) m_mode = M_RET;
      else m_mode = M_RUN;
    end else begin
      m_mode = M_RUN;
    end
  endtask

  initial begin
    vecs[0]  = '{1,0,0,0, K_NONE,      3'b000, 4'b0000, 2'b10, 4'd2,  0};
    vecs[1]  = '{0,0,0,0, K_ECALL,     3'b100, 4'b1100, 2'b10, 4'd11, 0};
    vecs[2]  = '{0,0,0,0, K_NONE,      3'b011, 4'b1011, 2'b10, 4'd3,  1};
    vecs[3]  = '{0,0,0,0, K_NONE,      3'b001, 4'b0001, 2'b11, 4'd3,  1};
    vecs[4]  = '{0,0,0,0, K_MRET,      3'b000, 4'b0000, 2'b01, 4'd3,  1};
    vecs[5]  = '{0,0,1,0, K_MRET,      3'b000, 4'b0000, 2'b10, 4'd4,  0};
    vecs[6]  = '{0,0,0,0, K_EBREAK,    3'b000, 4'b0000, 2'b10, 4'd3,  0};
    vecs[7]  = '{0,1,0,1, K_NONE,      3'b000, 4'b0000, 2'b10, 4'd0,  0};
    vecs[8]  = '{0,0,0,1, K_NONE,      3'b000, 4'b0000, 2'b10, 4'd6,  0};
    vecs[9]  = '{0,0,0,0, K_NONE,      3'b001, 4'b1001, 2'b10, 4'd7,  1};
    vecs[10] = '{0,0,0,0, K_NONE,      3'b100, 4'b1011, 2'b11, 4'd7,  1};
    vecs[11] = '{0,0,0,0, K_MRET_RD,   3'b000, 4'b0000, 2'b11, 4'd7,  1};
    vecs[12] = '{0,0,0,0, K_NONE,      3'b110, 4'b1110, 2'b10, 4'd11, 1};
    vecs[13] = '{1,0,0,0, K_NONE,      3'b001, 4'b1001, 2'b10, 4'd2,  0};

    // Reset behaviour and release timing
    clear_inputs();
    rst = 1;
    repeat (3) tick();
    check_outputs("rst", 2'b00);
    check("rst_cause", cause, 4'd0);
    check("rst_ioe", i_or_e, 1'b0);
    rst = 0;
    #1;
    check("rel_pc", pc_src, 2'b00);
    tick();
    check_outputs("run", 2'b11);

    // Table-driven single-cycle events from OPERATING
    for (int i = 0; i < 14; i++) begin
      ill = vecs[i].ill; mi = vecs[i].mi; ml = vecs[i].ml; ms = vecs[i].ms;
      set_instr(vecs[i].kind);
      {e_irq, s_irq, t_irq} = vecs[i].irq;
      {mie, meie, msie, mtie} = vecs[i].en;
      #1;
      check($sformatf("v%0d_misexc", i), mis_exc, vecs[i].mi | vecs[i].ml | vecs[i].ms);
      tick();
      check_outputs($sformatf("v%0d", i), vecs[i].exp_pc);
      check($sformatf("v%0d_cause", i), cause, vecs[i].exp_cause);
      check($sformatf("v%0d_ioe", i), i_or_e, vecs[i].exp_ioe);
      clear_inputs();
      tick();
      check($sformatf("v%0d_back", i), pc_src, 2'b11);
      check($sformatf("v%0d_hold", i), cause, vecs[i].exp_cause);
    end

    // Inputs ignored outside OPERATING; back-to-back trap from N+2
    ill = 1;
    tick(); check("b2b_1", pc_src, 2'b10);
    #1; check("b2b_misexc_trap", mis_exc, 1'b0);
    ml = 1; #1; check("misexc_gated", mis_exc, 1'b0);
    ml = 0;
    tick(); check("b2b_2", pc_src, 2'b11);
    tick(); check("b2b_3", pc_src, 2'b10);
    clear_inputs();
    tick(); check("b2b_4", pc_src, 2'b11);

    // Reset during TRAP_TAKEN
    ill = 1;
    tick(); check("mid_trap", pc_src, 2'b10);
    clear_inputs(); rst = 1;
    tick();
    check_outputs("rst_trap", 2'b00);
    check("rst_trap_cause", cause, 4'd0);
    rst = 0; tick(); tick();
    check("rst_trap_recover", pc_src, 2'b11);

    // Reset during TRAP_RETURN
    set_instr(K_MRET);
    tick(); check("mid_ret", pc_src, 2'b01);
    clear_inputs(); rst = 1;
    tick();
    check_outputs("rst_ret", 2'b00);
    rst = 0; tick(); tick();

    // Randomized stimulus against the reference model
    m_mode = M_RUN; m_cause = 0; m_ioe = 0;
    for (int n = 0; n < 500; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      ill   = ($urandom_range(0, 9) == 0);
      mi    = ($urandom_range(0, 15) == 0);
      ml    = ($urandom_range(0, 15) == 0);
      ms    = ($urandom_range(0, 15) == 0);
      set_instr($urandom_range(0, 5));
      e_irq = ($urandom_range(0, 5) == 0);
      s_irq = ($urandom_range(0, 5) == 0);
      t_irq = ($urandom_range(0, 5) == 0);
      mie   = 1'($urandom); meie = 1'($urandom); msie = 1'($urandom); mtie = 1'($urandom);
      #1;
      check("rnd_misexc", mis_exc, (m_mode == M_RUN) & (mi | ml | ms));
      model_step();
      tick();
      check_outputs("rnd", mode_pc(m_mode));
      check("rnd_cause", cause, m_cause);
      check("rnd_ioe", i_or_e, m_ioe);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
